truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Self-test sequencer for a 4-input, 2-output combinational decode block.
//  - Drives the block's {A,B,C,D} inputs through all 16 codes, 0000 to 1111, in ascending order.
//  - Waits a programmable settle time per code, then captures Y1/Y2 into 16-bit maps.
//  - Compares each capture against expected minterm masks and reports pass/fail with first-failure info.
//  - Sits between a test/bring-up controller (start/done handshake) and the decode block.
// PARAMETERS
//  SETTLE_CYCLES  2        cycles to wait after driving a code before sampling (legal range 1..15)
//  Y1_EXPECT      16'h38F0 expected Y1; bit i = output for code i (minterms 4,5,6,7,11,12,13)
//  Y2_EXPECT      16'h0036 expected Y2; bit i = output for code i (minterms 1,2,4,5)
//  STOP_ON_FAIL   0        1: end the sweep at the first mismatching code
// PORTS
//  clk             in   1   single clock; all state changes on its rising edge
//  rst             in   1   synchronous, active-high reset
//  start           in   1   request a sweep; sampled only in IDLE
//  busy            out  1   1 while a sweep is in progress
//  done            out  1   one-cycle pulse when a sweep ends
//  pass            out  1   1 = last sweep had no mismatch; valid from done, held until the next start
//  dut_abcd        out  4   {A,B,C,D} drive to the decode block (A = MSB)
//  dut_y1          in   1   Y1 from the decode block
//  dut_y2          in   1   Y2 from the decode block
//  y1_capture      out  16  captured Y1 map; bit i = sample for code i
//  y2_capture      out  16  captured Y2 map; bit i = sample for code i
//  fail_count      out  5   number of codes where Y1 or Y2 mismatched (0..16)
//  first_fail_idx  out  4   code of the first mismatch; meaningful only if fail_count != 0
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (busy, done, pass, dut_abcd, captures, fail_count, first_fail_idx).
//  States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
//  IDLE
//   - start=1: idx<=0, dut_abcd<=0, wait_cnt<=0; clear captures, fail_count, first_fail_idx, pass.
//   - Same edge: busy<=1, go to SETTLE.
//  SETTLE
//   - wait_cnt increments each cycle; dut_abcd is held stable.
//   - Leave for SAMPLE after exactly SETTLE_CYCLES cycles in SETTLE.
//  SAMPLE (one cycle)
//   - y1_capture[idx]<=dut_y1, y2_capture[idx]<=dut_y2.
//   - mismatch = (dut_y1 != Y1_EXPECT[idx]) | (dut_y2 != Y2_EXPECT[idx]).
//   - On mismatch: fail_count++; if fail_count was 0, first_fail_idx<=idx.
//   - If idx==15, or STOP_ON_FAIL && mismatch: go to DONE.
//   - Else: idx<=idx+1, dut_abcd<=idx+1, wait_cnt<=0, go to SETTLE.
//  DONE (one cycle)
//   - done=1, busy=0; pass<=(fail_count==0), using the count that includes the final SAMPLE.
//   - Go to IDLE. dut_abcd holds the last code driven.
//  Latency: each code costs SETTLE_CYCLES+1 cycles.
//   - Full sweep: done is high in cycle 16*(SETTLE_CYCLES+1)+1 after the start edge (49 at default).
//   - Early stop at code k: done in cycle (k+1)*(SETTLE_CYCLES+1)+1.
//  Boundary conditions
//   - start while busy or in DONE: ignored, no restart.
//   - start held high: a new sweep begins on the first IDLE cycle.
//   - idx does not wrap; code 15 always terminates the sweep.
//   - fail_count saturates naturally at 16 (5 bits).
//   - rst mid-sweep has priority over all state: immediate return to reset values, no done pulse.
//   - Captures and fail info stay stable between sweeps; they are cleared only by start or rst.
// TESTING
//  T1 golden DUT model, defaults:
//     start -> done at cycle 49, pass=1, fail_count=0,
//     y1_capture=16'h38F0, y2_capture=16'h0036.
//  T2 Y2 stuck-at-0:
//     done at 49, pass=0, fail_count=4, first_fail_idx=1, y2_capture=0.
//  T3 STOP_ON_FAIL=1, Y1 stuck-at-0:
//     done at cycle 16, fail_count=1, first_fail_idx=4, dut_abcd=4.
//  T4 rst asserted while dut_abcd=7:
//     next cycle all outputs 0, state IDLE, no done pulse;
//     a new start then completes a normal sweep.
//  T5 start pulsed at cycles 10 and 30 during a sweep: ignored, done still at 49.
//     start re-asserted on the IDLE cycle after done: captures and fail_count cleared, second sweep runs.
//  T6 SETTLE_CYCLES=1:
//     dut_abcd changes every 2 cycles, done at cycle 33, and every capture bit taken only after
//     at least one full settle cycle.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Self-test sequencer: walks a 4-input decode block through codes 0..15, captures
// Y1/Y2 after a settle delay and scores them against expected minterm masks.
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] Y1_EXPECT     = 16'h38F0,
  parameter logic [15:0] Y2_EXPECT     = 16'h0036,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  dut_abcd,
  input  logic        dut_y1,
  input  logic        dut_y2,
  output logic [15:0] y1_capture,
  output logic [15:0] y2_capture,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail_idx
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [3:0]  wait_cnt, wait_nxt;
  logic        busy_nxt, done_nxt, pass_nxt;
  logic [3:0]  abcd_nxt, ffi_nxt;
  logic [15:0] y1_nxt, y2_nxt;
  logic [4:0]  fc_nxt;
  logic        mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      wait_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      dut_abcd       <= '0;
      y1_capture     <= '0;
      y2_capture     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      wait_cnt       <= wait_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      dut_abcd       <= abcd_nxt;
      y1_capture     <= y1_nxt;
      y2_capture     <= y2_nxt;
      fail_count     <= fc_nxt;
      first_fail_idx <= ffi_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wait_nxt  = wait_cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pass_nxt  = pass;
    abcd_nxt  = dut_abcd;
    y1_nxt    = y1_capture;
    y2_nxt    = y2_capture;
    fc_nxt    = fail_count;
    ffi_nxt   = first_fail_idx;
    mismatch  = (dut_y1 != Y1_EXPECT[idx]) || (dut_y2 != Y2_EXPECT[idx]);

    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = '0;
          abcd_nxt  = '0;
          wait_nxt  = '0;
          y1_nxt    = '0;
          y2_nxt    = '0;
          fc_nxt    = '0;
          ffi_nxt   = '0;
          pass_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        wait_nxt = wait_cnt + 4'd1;
        if (wait_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        y1_nxt[idx] = dut_y1;
        y2_nxt[idx] = dut_y2;
        if (mismatch) begin
          fc_nxt = fail_count + 5'd1;
          if (fail_count == 5'd0) ffi_nxt = idx;
        end
        // done/pass are registered, so they are set on the way into DONE
        if (idx == 4'd15 || (STOP_ON_FAIL && mismatch)) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          pass_nxt  = (fc_nxt == 5'd0);
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx + 4'd1;
          abcd_nxt  = idx + 4'd1;
          wait_nxt  = '0;
          state_nxt = SETTLE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: three sweepers (default, stop-on-fail, 1-cycle settle) each
// driving a behavioural decode model with injectable stuck-at-0 faults.
module tb_truth_table_sweeper;

  localparam logic [15:0] Y1E = 16'h38F0;
  localparam logic [15:0] Y2E = 16'h0036;
  localparam logic [15:0] GOLD1 = 16'h38F0;
  localparam logic [15:0] GOLD2 = 16'h0036;

  typedef struct packed {
    logic        busy, done, pass;
    logic [3:0]  abcd;
    logic [15:0] y1, y2;
    logic [4:0]  fc;
    logic [3:0]  ffi;
  } snap_t;

  typedef struct {
    int    id;
    int    cyc;
    snap_t s;
    string tag;
  } rec_t;

  logic clk;
  logic [2:0] rst, start;
  int   cyc;
  logic fin;
  logic f_y2_0, f_y1_1;

  logic        busy0, done0, pass0, y1_0, y2_0;
  logic [3:0]  abcd0, ffi0;
  logic [15:0] cap1_0, cap2_0;
  logic [4:0]  fc0;
  logic        busy1, done1, pass1, y1_1, y2_1;
  logic [3:0]  abcd1, ffi1;
  logic [15:0] cap1_1, cap2_1;
  logic [4:0]  fc1;
  logic        busy2, done2, pass2, y1_2, y2_2;
  logic [3:0]  abcd2, ffi2, abcd2_d;
  logic [15:0] cap1_2, cap2_2;
  logic [4:0]  fc2;

  rec_t done_q[$];
  rec_t probe_q[$];
  int   n_cmp, n_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Decode-block models; instance 2 lags its input by one cycle to expose early sampling
  assign y1_0 = Y1E[abcd0];
  assign y2_0 = f_y2_0 ? 1'b0 : Y2E[abcd0];
  assign y1_1 = f_y1_1 ? 1'b0 : Y1E[abcd1];
  assign y2_1 = Y2E[abcd1];
  always @(posedge clk) abcd2_d <= abcd2;
  assign y1_2 = Y1E[abcd2_d];
  assign y2_2 = Y2E[abcd2_d];

  truth_table_sweeper u_def (
    .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy0), .done(done0), .pass(pass0),
    .dut_abcd(abcd0), .dut_y1(y1_0), .dut_y2(y2_0), .y1_capture(cap1_0), .y2_capture(cap2_0),
    .fail_count(fc0), .first_fail_idx(ffi0));

  truth_table_sweeper #(.STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy1), .done(done1), .pass(pass1),
    .dut_abcd(abcd1), .dut_y1(y1_1), .dut_y2(y2_1), .y1_capture(cap1_1), .y2_capture(cap2_1),
    .fail_count(fc1), .first_fail_idx(ffi1));

  truth_table_sweeper #(.SETTLE_CYCLES(1)) u_fast (
    .clk(clk), .rst(rst[2]), .start(start[2]), .busy(busy2), .done(done2), .pass(pass2),
    .dut_abcd(abcd2), .dut_y1(y1_2), .dut_y2(y2_2), .y1_capture(cap1_2), .y2_capture(cap2_2),
    .fail_count(fc2), .first_fail_idx(ffi2));

  function automatic snap_t cur(int id);
    snap_t s;
    case (id)
      0: s = '{busy0, done0, pass0, abcd0, cap1_0, cap2_0, fc0, ffi0};
      1: s = '{busy1, done1, pass1, abcd1, cap1_1, cap2_1, fc1, ffi1};
      default: s = '{busy2, done2, pass2, abcd2, cap1_2, cap2_2, fc2, ffi2};
    endcase
    return s;
  endfunction

  function automatic snap_t mk(logic b, logic d, logic p, logic [3:0] a, logic [15:0] c1,
                               logic [15:0] c2, logic [4:0] fc, logic [3:0] ffi);
    snap_t s;
    s = '{b, d, p, a, c1, c2, fc, ffi};
    return s;
  endfunction

  function automatic string show(snap_t s);
    return $sformatf("busy=%0b done=%0b pass=%0b abcd=%h y1=%h y2=%h fc=%0d ffi=%0d",
                     s.busy, s.done, s.pass, s.abcd, s.y1, s.y2, s.fc, s.ffi);
  endfunction

  // Monitor: the only place comparisons are made and counted
  always @(negedge clk) begin
    snap_t a;
    rec_t  r;
    for (int d = 0; d < 3; d++) begin
      a = cur(d);
      if (a.done) begin
        n_cmp++;
        if (done_q.size() == 0 || done_q[0].id != d) begin
          n_bad++;
          $display("FAIL unexpected_done dut%0d cyc %0d: got %s, required no done", d, cyc, show(a));
        end else begin
          r = done_q.pop_front();
          if (a !== r.s || cyc != r.cyc) begin
            n_bad++;
            $display("FAIL %s dut%0d: got cyc %0d %s, required cyc %0d %s",
                     r.tag, d, cyc, show(a), r.cyc, show(r.s));
          end
        end
      end
    end
    while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
      r = probe_q.pop_front();
      a = cur(r.id);
      n_cmp++;
      if (r.cyc != cyc || a !== r.s) begin
        n_bad++;
        $display("FAIL %s dut%0d: got cyc %0d %s, required cyc %0d %s",
                 r.tag, r.id, cyc, show(a), r.cyc, show(r.s));
      end
    end
    if (fin) begin
      while (done_q.size() > 0) begin
        r = done_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout dut%0d: got no done, required done at cyc %0d", r.tag, r.id, r.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_done(int id, int c, snap_t s, string tag);
    rec_t r;
    r = '{id, c, s, tag};
    done_q.push_back(r);
  endtask

  task automatic push_probe(int id, int c, snap_t s, string tag);
    rec_t r;
    r = '{id, c, s, tag};
    probe_q.push_back(r);
  endtask

  task automatic go(int id);
    start[id] = 1'b1;
    tick(1);
    start[id] = 1'b0;
  endtask

  initial begin
    int n;
    snap_t gold, zero;
    cyc = 0; n_cmp = 0; n_bad = 0; fin = 1'b0;
    rst = 3'b111; start = 3'b000; f_y2_0 = 1'b0; f_y1_1 = 1'b0;
    gold = mk(0, 1, 1, 4'd15, GOLD1, GOLD2, 5'd0, 4'd0);
    zero = mk(0, 0, 0, 4'd0, 16'h0, 16'h0, 5'd0, 4'd0);
    tick(3);
    rst = 3'b000;
    for (int d = 0; d < 3; d++) push_probe(d, cyc, zero, "reset");
    tick(2);

    // T1 golden full sweep
    n = cyc;
    push_done(0, n + 49, gold, "t1_golden");
    go(0); tick(52);

    // T2 Y2 stuck-at-0
    f_y2_0 = 1'b1;
    n = cyc;
    push_done(0, n + 49, mk(0, 1, 0, 4'd15, GOLD1, 16'h0, 5'd4, 4'd1), "t2_y2_sa0");
    go(0); tick(52);
    f_y2_0 = 1'b0;

    // T3 stop on first fail, Y1 stuck-at-0; results must hold after done
    f_y1_1 = 1'b1;
    n = cyc;
    push_done(1, n + 16, mk(0, 1, 0, 4'd4, 16'h0, 16'h0016, 5'd1, 4'd4), "t3_stop");
    push_probe(1, n + 20, mk(0, 0, 0, 4'd4, 16'h0, 16'h0016, 5'd1, 4'd4), "t3_hold");
    go(1); tick(20);
    f_y1_1 = 1'b0;

    // T4 reset mid-sweep at code 7, then a clean sweep
    n = cyc;
    push_probe(0, n + 22, mk(1, 0, 0, 4'd7, 16'h0070, 16'h0036, 5'd0, 4'd0), "t4_code7");
    push_probe(0, n + 23, zero, "t4_after_rst");
    go(0); tick(21);
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    tick(60);
    n = cyc;
    push_done(0, n + 49, gold, "t4_resweep");
    go(0); tick(52);

    // T5 start pulses mid-sweep ignored; restart on first IDLE cycle clears results
    f_y2_0 = 1'b1;
    n = cyc;
    push_done(0, n + 49, mk(0, 1, 0, 4'd15, GOLD1, 16'h0, 5'd4, 4'd1), "t5_first");
    go(0); tick(9);
    go(0); tick(19);
    go(0); tick(19);
    f_y2_0 = 1'b0;
    n = cyc;
    push_probe(0, n + 1, mk(1, 0, 0, 4'd0, 16'h0, 16'h0, 5'd0, 4'd0), "t5_cleared");
    push_done(0, n + 49, gold, "t5_second");
    go(0); tick(52);

    // T6 one-cycle settle against a decode model with one cycle of latency
    n = cyc;
    push_probe(2, n + 1, mk(1, 0, 0, 4'd0, 16'h0, 16'h0, 5'd0, 4'd0), "t6_c1");
    push_probe(2, n + 3, mk(1, 0, 0, 4'd1, 16'h0, 16'h0, 5'd0, 4'd0), "t6_c3");
    push_probe(2, n + 4, mk(1, 0, 0, 4'd1, 16'h0, 16'h0, 5'd0, 4'd0), "t6_c4");
    push_probe(2, n + 5, mk(1, 0, 0, 4'd2, 16'h0, 16'h0002, 5'd0, 4'd0), "t6_c5");
    push_done(2, n + 33, gold, "t6_fast");
    go(2); tick(36);

    fin = 1'b1;
    tick(3);
  end

endmodule
